// File: rtl/fifo_block_assembler_pkg.sv
// rtl/fifo_block_assembler_pkg.sv - shared widths and FSM encoding for the block assembler
//
// Purpose : default FIFO word / operand widths and the two-state FSM encoding
//           shared by the assembler interface and the assembler itself.
// Ports   : none (package).
package fifo_block_assembler_pkg;

   // Defaults: 16-bit operand FIFO feeding a 256-bit modexp operand.
   localparam int ASM_DATA_WIDTH  = 16;
   localparam int ASM_BLOCK_WIDTH = 256;

   // FILL: popping/capturing words. HOLD: block presented, waiting for the core.
   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } asm_state_e;

   // Number of FIFO words making up one operand.
   function automatic int asm_words(input int data_width, input int block_width);
      return block_width / data_width;
   endfunction

endpackage

// File: rtl/fifo_block_assembler_if.sv
// rtl/fifo_block_assembler_if.sv - FIFO read side and block handshake bundle
//
// Purpose : groups the FIFO read port and the block valid/ready port used by
//           the assembler.
// Ports   : fifo_empty (FIFO -> asm), fifo_rd_en (asm -> FIFO),
//           fifo_data (FIFO -> asm, one cycle after an accepted read),
//           blk_valid / blk_data (asm -> core), blk_ready (core -> asm).
// Modports: master = assembler side, slave = FIFO/core environment side.
interface fifo_block_assembler_if
   import fifo_block_assembler_pkg::*;
#(
   parameter int DATA_WIDTH  = ASM_DATA_WIDTH,
   parameter int BLOCK_WIDTH = ASM_BLOCK_WIDTH
) ();

   logic                   fifo_empty;
   logic                   fifo_rd_en;
   logic [DATA_WIDTH-1:0]  fifo_data;
   logic                   blk_valid;
   logic                   blk_ready;
   logic [BLOCK_WIDTH-1:0] blk_data;

   modport master (
      input  fifo_empty,
      output fifo_rd_en,
      input  fifo_data,
      output blk_valid,
      input  blk_ready,
      output blk_data
   );

   modport slave (
      output fifo_empty,
      input  fifo_rd_en,
      output fifo_data,
      input  blk_valid,
      output blk_ready,
      input  blk_data
   );

endinterface

// File: rtl/fifo_block_assembler.sv
// rtl/fifo_block_assembler.sv - packs FIFO words into one wide operand for the modexp core
//
// Purpose : pops DATA_WIDTH-bit words from the operand FIFO, packs WORDS of
//           them into a BLOCK_WIDTH-bit operand and offers it over valid/ready.
//           The FIFO has one cycle of read latency, so a read is tracked as
//           "issued" when requested and "captured" one cycle later.
// Ports   : clk   - system clock, rising edge
//           rst_n - asynchronous active-low reset
//           flush - synchronous abort of the partial block, active high
//           bus   - fifo_block_assembler_if.master (FIFO read port + block handshake)
// Options : ASM_MSW_FIRST_EN - when defined, the first captured word lands in the
//           most significant slot and later words fill downward; otherwise the
//           first word lands in the least significant slot.
module fifo_block_assembler
   import fifo_block_assembler_pkg::*;
#(
   parameter int DATA_WIDTH  = ASM_DATA_WIDTH,
   parameter int BLOCK_WIDTH = ASM_BLOCK_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          flush,
   fifo_block_assembler_if.master        bus
);

   localparam int WORDS = asm_words(DATA_WIDTH, BLOCK_WIDTH);
   localparam int CNT_W = $clog2(WORDS) + 1;

   localparam logic [CNT_W-1:0] WORDS_C = CNT_W'(WORDS);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   asm_state_e             state_q,      state_d;
   logic [CNT_W-1:0]       issued_cnt_q, issued_cnt_d;
   logic [CNT_W-1:0]       cap_cnt_q,    cap_cnt_d;
   logic                   rd_pending_q, rd_pending_d;
   logic [BLOCK_WIDTH-1:0] blk_data_q,   blk_data_d;

   logic                   rd_en;
   logic                   xfer;
   logic [CNT_W-1:0]       slot;

   // Reads are only requested while filling and while the block still needs
   // words; issued_cnt saturating at WORDS is what prevents over-reading the
   // FIFO into the next block before this one is handed over. rst_n gates the
   // request so the FIFO sees no pop while reset is held.
   assign rd_en = rst_n & (state_q == FILL) & ~bus.fifo_empty &
                  (issued_cnt_q < WORDS_C) & ~flush;

   assign xfer = (state_q == HOLD) & bus.blk_ready;

   // Destination slot of the word being captured this cycle.
`ifdef ASM_MSW_FIRST_EN
   assign slot = WORDS_C - ONE_C - cap_cnt_q;
`else
   assign slot = cap_cnt_q;
`endif

   always_comb begin
      state_d      = state_q;
      issued_cnt_d = issued_cnt_q;
      cap_cnt_d    = cap_cnt_q;
      rd_pending_d = 1'b0;
      blk_data_d   = blk_data_q;

      if (flush) begin
         // Abort: any word still in flight from the FIFO is dropped because
         // rd_pending_d stays 0 and nothing is written this cycle.
         state_d      = FILL;
         issued_cnt_d = '0;
         cap_cnt_d    = '0;
      end else begin
         case (state_q)
            FILL: begin
               if (rd_en) begin
                  issued_cnt_d = issued_cnt_q + ONE_C;
                  rd_pending_d = 1'b1;
               end
               if (rd_pending_q) begin
                  for (int i = 0; i < WORDS; i++) begin
                     if (slot == CNT_W'(i)) begin
                        blk_data_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.fifo_data;
                     end
                  end
                  cap_cnt_d = cap_cnt_q + ONE_C;
                  if (cap_cnt_d == WORDS_C) begin
                     state_d = HOLD;
                  end
               end
            end
            HOLD: begin
               if (xfer) begin
                  state_d      = FILL;
                  issued_cnt_d = '0;
                  cap_cnt_d    = '0;
               end
            end
            default: begin
               state_d = FILL;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= FILL;
         issued_cnt_q <= '0;
         cap_cnt_q    <= '0;
         rd_pending_q <= 1'b0;
         blk_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         issued_cnt_q <= issued_cnt_d;
         cap_cnt_q    <= cap_cnt_d;
         rd_pending_q <= rd_pending_d;
         blk_data_q   <= blk_data_d;
      end
   end

   // blk_valid comes straight from the state register, never from blk_ready.
   assign bus.fifo_rd_en = rd_en;
   assign bus.blk_valid  = (state_q == HOLD);
   assign bus.blk_data   = blk_data_q;

endmodule

// File: tb/tb_fifo_block_assembler.sv
// tb/tb_fifo_block_assembler.sv - self-checking bench for fifo_block_assembler
module tb_fifo_block_assembler;

   localparam int DW    = 16;
   localparam int BW    = 256;
   localparam int WORDS = BW / DW;

   logic clk = 1'b0;
   logic rst_n;
   logic flush;

   always #5 clk = ~clk;

   fifo_block_assembler_if #(.DATA_WIDTH(DW), .BLOCK_WIDTH(BW)) bus ();

   fifo_block_assembler #(.DATA_WIDTH(DW), .BLOCK_WIDTH(BW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // FIFO contents, words of the block being accumulated, expected blocks
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] acc_q[$];
   logic [BW-1:0] exp_q[$];

   int            pop_total  = 0;
   int            xfer_total = 0;
   logic          last_rd, last_v, last_xfer, last_empty;
   logic          prev_v = 1'b0, prev_r = 1'b0, prev_x = 1'b0;
   logic          prev_rstn = 1'b0, prev_flush = 1'b0;
   logic [BW-1:0] prev_d = '0;
   logic [BW-1:0] last_xfer_data = '0;

   function automatic logic [BW-1:0] pack_acc();
      logic [BW-1:0] b;
      b = '0;
      for (int i = 0; i < WORDS; i++) begin
`ifdef ASM_MSW_FIRST_EN
         b[(WORDS-1-i)*DW +: DW] = acc_q[i];
`else
         b[i*DW +: DW] = acc_q[i];
`endif
      end
      return b;
   endfunction

   task automatic push_raw(input logic [DW-1:0] w);
      fifo_q.push_back(w);
      bus.fifo_empty = 1'b0;
   endtask

   // Every WORDS consecutive words pushed form one expected block.
   task automatic push_word(input logic [DW-1:0] w);
      push_raw(w);
      acc_q.push_back(w);
      if (acc_q.size() == WORDS) begin
         exp_q.push_back(pack_acc());
         acc_q.delete();
      end
   endtask

   // One clock: sample at negedge, check, then model the FIFO after posedge.
   task automatic step();
      logic          rd, v, r, rs;
      logic [BW-1:0] d, e;
      @(negedge clk);
      rd = bus.fifo_rd_en;
      v  = bus.blk_valid;
      r  = bus.blk_ready;
      d  = bus.blk_data;
      rs = rst_n;
      last_empty = (fifo_q.size() == 0);
      checks++;
      if (rd && last_empty) begin
         errors++;
         $display("FAIL rd_on_empty: fifo_rd_en=%b while FIFO empty, required 0", rd);
      end
      if (rs && prev_rstn) begin
         if (prev_v && !prev_r && !prev_flush) begin
            checks++;
            if (v !== 1'b1 || d !== prev_d) begin
               errors++;
               $display("FAIL hold_stable: valid=%b data=%h, required valid=1 data=%h", v, d, prev_d);
            end
         end
         if (prev_x) begin
            checks++;
            if (v !== 1'b0) begin
               errors++;
               $display("FAIL valid_drop: blk_valid=%b after transfer, required 0", v);
            end
         end
      end
      if (rs && v && r) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_block: got %h, required no block", d);
         end else begin
            e = exp_q.pop_front();
            if (d !== e) begin
               errors++;
               $display("FAIL block_data: got %h, required %h", d, e);
            end
         end
         xfer_total++;
         last_xfer_data = d;
      end
      last_rd    = rd;
      last_v     = v;
      last_xfer  = rs & v & r;
      prev_v     = v;
      prev_r     = r;
      prev_x     = rs & v & r;
      prev_d     = d;
      prev_rstn  = rs;
      prev_flush = flush;
      @(posedge clk);
      #1;
      if (rd && !last_empty) begin
         bus.fifo_data = fifo_q.pop_front();
         pop_total++;
      end
      bus.fifo_empty = (fifo_q.size() == 0);
   endtask

   task automatic run_until(input int target, input int budget);
      int n;
      n = 0;
      while (xfer_total < target && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (xfer_total < target) begin
         errors++;
         $display("FAIL timeout: %0d transfers, required %0d", xfer_total, target);
      end
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      flush          = 1'b0;
      bus.blk_ready  = 1'b0;
      fifo_q.delete();
      acc_q.delete();
      bus.fifo_empty = 1'b1;
      bus.fifo_data  = '0;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover_blocks: %0d undelivered, required 0", exp_q.size());
      end
      exp_q.delete();
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic async_reset_pulse();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.blk_valid !== 1'b0 || bus.fifo_rd_en !== 1'b0 || bus.blk_data !== '0) begin
         errors++;
         $display("FAIL async_reset: valid=%b rd_en=%b data=%h, required 0 0 0",
                  bus.blk_valid, bus.fifo_rd_en, bus.blk_data);
      end
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n          = 1'b0;
      flush          = 1'b0;
      bus.blk_ready  = 1'b1;
      bus.fifo_empty = 1'b0;
      bus.fifo_data  = '0;
      #2;
      checks++;
      if (bus.blk_valid !== 1'b0 || bus.fifo_rd_en !== 1'b0 || bus.blk_data !== '0) begin
         errors++;
         $display("FAIL reset_state: valid=%b rd_en=%b data=%h, required 0 0 0",
                  bus.blk_valid, bus.fifo_rd_en, bus.blk_data);
      end
      do_reset();
   endtask

   task automatic test_basic();
      int first_rd, last_rd_i, rd_cnt, first_v, v_cnt;
      logic [BW-1:0] want;
      do_reset();
      bus.blk_ready = 1'b1;
      for (int i = 1; i <= WORDS; i++) push_word(DW'(i));
      first_rd = -1; last_rd_i = -1; rd_cnt = 0; first_v = -1; v_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (last_rd) begin
            if (first_rd < 0) first_rd = i;
            last_rd_i = i;
            rd_cnt++;
         end
         if (last_v) begin
            if (first_v < 0) first_v = i;
            v_cnt++;
         end
      end
      checks++;
      if (rd_cnt != WORDS || last_rd_i - first_rd != WORDS - 1) begin
         errors++;
         $display("FAIL basic_reads: %0d reads over %0d cycles, required %0d consecutive",
                  rd_cnt, last_rd_i - first_rd + 1, WORDS);
      end
      checks++;
      if (first_v - first_rd != WORDS + 1) begin
         errors++;
         $display("FAIL basic_latency: valid at cycle %0d, required %0d", first_v - first_rd, WORDS + 1);
      end
      checks++;
      if (v_cnt != 1) begin
         errors++;
         $display("FAIL basic_single_valid: %0d valid cycles, required 1", v_cnt);
      end
`ifdef ASM_MSW_FIRST_EN
      want = 256'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000a_000b_000c_000d_000e_000f_0010;
`else
      want = 256'h0010_000f_000e_000d_000c_000b_000a_0009_0008_0007_0006_0005_0004_0003_0002_0001;
`endif
      checks++;
      if (last_xfer_data !== want) begin
         errors++;
         $display("FAIL basic_order: got %h, required %h", last_xfer_data, want);
      end
   endtask

   task automatic test_backpressure();
      int rd_cnt, base;
      logic [DW-1:0] want;
      do_reset();
      bus.blk_ready = 1'b0;
      for (int i = 1; i <= 40; i++) push_word(DW'(i));
      rd_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (last_rd) rd_cnt++;
      end
      checks++;
      if (rd_cnt != WORDS || last_v !== 1'b1 || fifo_q.size() != 40 - WORDS) begin
         errors++;
         $display("FAIL backpressure: reads=%0d valid=%b fifo=%0d, required %0d 1 %0d",
                  rd_cnt, last_v, fifo_q.size(), WORDS, 40 - WORDS);
      end
      base = xfer_total;
      bus.blk_ready = 1'b1;
      run_until(base + 2, 80);
`ifdef ASM_MSW_FIRST_EN
      want = 16'h0020;
`else
      want = 16'h0011;
`endif
      checks++;
      if (last_xfer_data[DW-1:0] !== want || fifo_q.size() != 8) begin
         errors++;
         $display("FAIL backpressure_second: lsw=%h fifo=%0d, required %h 8",
                  last_xfer_data[DW-1:0], fifo_q.size(), want);
      end
   endtask

   task automatic test_gap();
      int rd_cnt;
      do_reset();
      bus.blk_ready = 1'b1;
      for (int i = 0; i < 5; i++) push_word(DW'($urandom));
      rd_cnt = 0;
      for (int i = 0; i < 25; i++) begin
         step();
         if (last_rd) rd_cnt++;
      end
      checks++;
      if (rd_cnt != 5 || last_v !== 1'b0) begin
         errors++;
         $display("FAIL gap_stall: reads=%0d valid=%b, required 5 0", rd_cnt, last_v);
      end
      for (int i = 0; i < 11; i++) push_word(DW'($urandom));
      run_until(xfer_total + 1, 40);
   endtask

   task automatic test_flush();
      logic [DW-1:0] w[30];
      int base, n;
      do_reset();
      bus.blk_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         w[i] = DW'($urandom);
         push_raw(w[i]);
      end
      base = pop_total;
      n = 0;
      while (pop_total - base < 7 && n < 30) begin
         step();
         n++;
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      checks++;
      if (last_rd !== 1'b0 || last_empty) begin
         errors++;
         $display("FAIL flush_rd: fifo_rd_en=%b during flush, required 0", last_rd);
      end
      for (int i = 7; i < 7 + WORDS; i++) acc_q.push_back(w[i]);
      exp_q.push_back(pack_acc());
      acc_q.delete();
      run_until(xfer_total + 1, 60);
      checks++;
`ifdef ASM_MSW_FIRST_EN
      if (last_xfer_data[BW-1 -: DW] !== w[7]) begin
         errors++;
         $display("FAIL flush_first_word: got %h, required %h", last_xfer_data[BW-1 -: DW], w[7]);
      end
`else
      if (last_xfer_data[DW-1:0] !== w[7]) begin
         errors++;
         $display("FAIL flush_first_word: got %h, required %h", last_xfer_data[DW-1:0], w[7]);
      end
`endif
   endtask

   task automatic test_flush_xfer();
      int n;
      do_reset();
      bus.blk_ready = 1'b0;
      for (int i = 0; i < WORDS; i++) push_word(DW'($urandom));
      n = 0;
      last_v = 1'b0;
      while (!last_v && n < 30) begin
         step();
         n++;
      end
      bus.blk_ready = 1'b1;
      flush = 1'b1;
      step();
      flush = 1'b0;
      checks++;
      if (last_xfer !== 1'b1) begin
         errors++;
         $display("FAIL flush_xfer: transfer=%b, required 1", last_xfer);
      end
      step();
      checks++;
      if (last_v !== 1'b0) begin
         errors++;
         $display("FAIL flush_xfer_valid: blk_valid=%b, required 0", last_v);
      end
      for (int i = 0; i < WORDS; i++) push_word(DW'($urandom));
      run_until(xfer_total + 1, 40);
   endtask

   task automatic test_reset_mid();
      int base, n;
      do_reset();
      bus.blk_ready = 1'b0;
      for (int i = 0; i < WORDS; i++) push_raw(DW'($urandom));
      for (int i = 0; i < 20; i++) step();
      checks++;
      if (last_v !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_hold: blk_valid=%b, required 1", last_v);
      end
      async_reset_pulse();
      bus.blk_ready = 1'b1;
      for (int i = 0; i < 10; i++) push_raw(DW'($urandom));
      base = pop_total;
      n = 0;
      while (pop_total - base < 10 && n < 40) begin
         step();
         n++;
      end
      step();
      step();
      for (int i = 0; i < 6; i++) push_raw(DW'($urandom));
      async_reset_pulse();
      acc_q = fifo_q;
      for (int i = 0; i < 10; i++) push_word(DW'($urandom));
      run_until(xfer_total + 1, 60);
   endtask

   task automatic test_empty();
      int rd_cnt;
      do_reset();
      bus.blk_ready = 1'b1;
      rd_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (last_rd) rd_cnt++;
      end
      checks++;
      if (rd_cnt != 0) begin
         errors++;
         $display("FAIL empty_reads: %0d reads, required 0", rd_cnt);
      end
   endtask

   task automatic test_back_to_back();
      int base_x, base_p, n;
      logic px;
      do_reset();
      bus.blk_ready = 1'b1;
      for (int i = 0; i < 3 * WORDS; i++) push_word(DW'($urandom));
      base_x = xfer_total;
      base_p = pop_total;
      px = 1'b0;
      n = 0;
      while (xfer_total < base_x + 3 && n < 100) begin
         step();
         if (px && !last_empty) begin
            checks++;
            if (last_rd !== 1'b1) begin
               errors++;
               $display("FAIL b2b_gap: fifo_rd_en=%b after transfer, required 1", last_rd);
            end
         end
         px = last_xfer;
         n++;
      end
      for (int i = 0; i < 5; i++) step();
      checks++;
      if (xfer_total != base_x + 3 || pop_total - base_p != 3 * WORDS) begin
         errors++;
         $display("FAIL b2b_counts: transfers=%0d pops=%0d, required 3 %0d",
                  xfer_total - base_x, pop_total - base_p, 3 * WORDS);
      end
   endtask

   task automatic test_random();
      int base_x, base_p, pushed, k, want_pops;
      do_reset();
      base_x = xfer_total;
      base_p = pop_total;
      pushed = 0;
      for (int c = 0; c < 500; c++) begin
         bus.blk_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) == 0) begin
            k = $urandom_range(1, 3);
            for (int j = 0; j < k; j++) push_word(DW'($urandom));
            pushed += k;
         end
         step();
      end
      bus.blk_ready = 1'b1;
      run_until(xfer_total + exp_q.size(), 20 * (exp_q.size() + 2));
      for (int i = 0; i < 25; i++) step();
      want_pops = WORDS * (xfer_total - base_x + 1);
      if (pushed < want_pops) want_pops = pushed;
      checks++;
      if (pop_total - base_p != want_pops) begin
         errors++;
         $display("FAIL random_pops: %0d pops, required %0d", pop_total - base_p, want_pops);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_gap();
      test_flush();
      test_flush_xfer();
      test_reset_mid();
      test_empty();
      test_back_to_back();
      test_random();
      do_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
